// File: rtl/seg7_pkg.sv
// seg7_pkg: shared FSM states, segment patterns and scan defaults for the 7-segment scan controller
package seg7_pkg;
  typedef enum logic [1:0] {S_OFF, S_GUARD, S_DRIVE} state_t;
  localparam int DEF_SCAN_DIV = 16;
  localparam int DEF_GUARD = 2;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_INVALID = 7'b0011111;
  // Active-low {a,b,c,d,e,f,g}, indexed by BCD code; codes 10-15 show SEG_INVALID.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, SEG_INVALID, SEG_INVALID,
    SEG_INVALID, SEG_INVALID, SEG_INVALID, SEG_INVALID
  };
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational BCD to active-low 7-segment pattern
//   bcd : 4-bit digit code
//   seg : {a,b,c,d,e,f,g}, active-low
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[bcd];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit multiplexed 7-segment scanner with guard time, blanking and frame-aligned data commit
//   clk, rst    : clock, asynchronous active-high reset
//   en          : 1 = scanning, 0 = display dark
//   load        : strobe capturing digits_in / dp_in / blank_in into the pending buffer
//   digits_in   : four BCD digits, [3:0] = digit 0
//   dp_in       : decimal point per digit, 1 = lit
//   blank_in    : forced blank per digit, 1 = dark
//   lz_en       : leading-zero suppression enable
//   seg_out     : active-low segments, [7] = dp, [6:0] = {a..g}
//   an_out      : active-low anode select, bit i = digit i
//   ack         : pulse when new data becomes the displayed data
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int GUARD = DEF_GUARD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en,
  output logic [7:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        ack
);
  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [1:0] idx, idx_nx;
  logic [15:0] act_dig, pend_dig;
  logic [3:0] act_dp, act_blank, pend_dp, pend_blank;
  logic pend;
  logic slot_end, commit, take, supp;
  logic [3:0] cur, lz_zero;
  logic [6:0] dec;
  logic [7:0] seg_nx;
  logic [3:0] an_nx;
  assign slot_end = state == S_DRIVE && cnt == 16'(SCAN_DIV - 1);
  // Data only changes at a frame boundary (idx 3 -> 0) or while dark.
  assign commit = state == S_OFF || (en && slot_end && idx == 2'd3);
  assign take = commit && (pend || load);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    idx_nx = idx;
    if (!en) begin
      state_nx = S_OFF;
      cnt_nx = '0;
      idx_nx = '0;
    end else if (state == S_OFF) state_nx = S_GUARD;
    else begin
      cnt_nx = slot_end ? '0 : cnt + 16'd1;
      idx_nx = slot_end ? idx + 2'd1 : idx;
      state_nx = slot_end ? S_GUARD : (state == S_GUARD && cnt == 16'(GUARD - 1)) ? S_DRIVE : state;
    end
  end
  assign cur = act_dig[idx*4 +: 4];
  seg7_digit_decode u_dec (.bcd(cur), .seg(dec));
  // lz_zero[i]: digit i and every more-significant digit are zero; digit 0 always shown.
  assign lz_zero[3] = act_dig[15:12] == 4'd0;
  assign lz_zero[2] = lz_zero[3] && act_dig[11:8] == 4'd0;
  assign lz_zero[1] = lz_zero[2] && act_dig[7:4] == 4'd0;
  assign lz_zero[0] = 1'b0;
  assign supp = act_blank[idx] || (lz_en && lz_zero[idx]);
  assign seg_nx = state == S_DRIVE && !supp ? {~act_dp[idx], dec} : SEG_BLANK;
  assign an_nx = state == S_DRIVE ? ~(4'b0001 << idx) : 4'hF;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      cnt <= '0;
      idx <= '0;
      pend <= 1'b0;
      pend_dig <= '0;
      pend_dp <= '0;
      pend_blank <= 4'hF;
      act_dig <= '0;
      act_dp <= '0;
      act_blank <= 4'hF;
      seg_out <= SEG_BLANK;
      an_out <= 4'hF;
      ack <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      pend <= commit ? 1'b0 : (load || pend);
      pend_dig <= load ? digits_in : pend_dig;
      pend_dp <= load ? dp_in : pend_dp;
      pend_blank <= load ? blank_in : pend_blank;
      act_dig <= take ? (load ? digits_in : pend_dig) : act_dig;
      act_dp <= take ? (load ? dp_in : pend_dp) : act_dp;
      act_blank <= take ? (load ? blank_in : pend_blank) : act_blank;
      seg_out <= seg_nx;
      an_out <= an_nx;
      ack <= take;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed, table-driven bench for seg7_scan_ctrl with SCAN_DIV=8, GUARD=2
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, rst, en, load, lz_en, ack;
  logic [15:0] digits_in;
  logic [3:0] dp_in, blank_in, an_out;
  logic [7:0] seg_out;
  int vecs = 0, miscompares = 0, ack_cnt = 0, base;
  typedef struct {
    logic [15:0] d;
    logic [3:0] dp;
    logic [3:0] bl;
    logic lz;
    logic [3:0][7:0] segs;
  } vec_t;
  vec_t vt [8];
  logic [3:0] exp_an;

  seg7_scan_ctrl #(.SCAN_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
    .seg_out(seg_out), .an_out(an_out), .ack(ack)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    vecs++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (an_out === pat) break;
    end
    check("wait an_out", {12'd0, an_out}, {12'd0, pat});
  endtask

  task automatic wait_ack();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ack === 1'b1) break;
    end
    check("ack seen", {15'd0, ack}, 16'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d;
    dp_in = dp;
    blank_in = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h1234, 4'b0100, 4'b0000, 1'b0, {8'b11001111, 8'b00010010, 8'b10000110, 8'b11001100}};
    vt[1] = '{16'h0070, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'b10001111, 8'b10000001}};
    vt[2] = '{16'h0070, 4'b0000, 4'b0000, 1'b0, {8'b10000001, 8'b10000001, 8'b10001111, 8'b10000001}};
    vt[3] = '{16'h000C, 4'b0000, 4'b0000, 1'b0, {8'b10000001, 8'b10000001, 8'b10000001, 8'b10011111}};
    vt[4] = '{16'h5678, 4'b0010, 4'b0010, 1'b0, {8'b10100100, 8'b10100000, 8'hFF, 8'b10000000}};
    vt[5] = '{16'h0005, 4'b1111, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'b00100100}};
    vt[6] = '{16'h9000, 4'b0000, 4'b0000, 1'b1, {8'b10000100, 8'b10000001, 8'b10000001, 8'b10000001}};
    vt[7] = '{16'h0800, 4'b0000, 4'b0001, 1'b1, {8'hFF, 8'b10000000, 8'b10000001, 8'hFF}};
    rst = 1'b1; en = 1'b1; load = 1'b0; lz_en = 1'b0;
    digits_in = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    check("reset an_out", {12'd0, an_out}, 16'h000F);
    check("reset seg_out", {8'd0, seg_out}, 16'h00FF);
    check("reset ack", {15'd0, ack}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first edge an_out", {12'd0, an_out}, 16'h000F);
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      exp_an = (s % 8 < 2) ? 4'hF : ~(4'b0001 << ((s / 8) % 4));
      check($sformatf("scan s%0d", s), {12'd0, an_out}, {12'd0, exp_an});
      if (s == 5) check("reset data blank", {8'd0, seg_out}, 16'h00FF);
    end
    for (int k = 0; k < 8; k++) begin
      lz_en = vt[k].lz;
      do_load(vt[k].d, vt[k].dp, vt[k].bl);
      wait_ack();
      for (int i = 0; i < 4; i++) begin
        wait_an(~(4'b0001 << i));
        check($sformatf("v%0d digit%0d", k, i), {8'd0, seg_out}, {8'd0, vt[k].segs[i]});
      end
    end
    lz_en = 1'b0;
    wait_an(4'b1110);
    base = ack_cnt;
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_ack();
    for (int i = 0; i < 4; i++) begin
      wait_an(~(4'b0001 << i));
      check($sformatf("last-wins digit%0d", i), {8'd0, seg_out}, 16'h0092);
    end
    repeat (10) @(negedge clk);
    check("last-wins ack count", 16'(ack_cnt - base), 16'd1);
    wait_an(4'b1011);
    wait_an(4'b1111);
    wait_an(4'b0111);
    repeat (4) @(negedge clk);
    base = ack_cnt;
    do_load(16'h4321, 4'b0000, 4'b0000);
    check("bypass ack", {15'd0, ack}, 16'd1);
    @(negedge clk);
    check("bypass ack single", {15'd0, ack}, 16'd0);
    wait_an(4'b1110);
    check("bypass digit0", {8'd0, seg_out}, 16'h00CF);
    repeat (40) @(negedge clk);
    check("bypass ack count", 16'(ack_cnt - base), 16'd1);
    wait_an(4'b1101);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en off an_out", {12'd0, an_out}, 16'h000F);
    check("en off seg_out", {8'd0, seg_out}, 16'h00FF);
    lz_en = 1'b1;
    do_load(16'h0008, 4'b0000, 4'b0000);
    check("disabled load ack", {15'd0, ack}, 16'd1);
    en = 1'b1;
    wait_an(4'b1110);
    check("re-enable digit0", {8'd0, seg_out}, 16'h0080);
    wait_an(4'b0111);
    check("re-enable digit3", {8'd0, seg_out}, 16'h00FF);
    lz_en = 1'b0;
    wait_an(4'b1101);
    do_load(16'h9999, 4'b0000, 4'b0000);
    #2 rst = 1'b1;
    #1;
    check("async rst an_out", {12'd0, an_out}, 16'h000F);
    check("async rst seg_out", {8'd0, seg_out}, 16'h00FF);
    check("async rst ack", {15'd0, ack}, 16'd0);
    repeat (3) @(negedge clk);
    base = ack_cnt;
    rst = 1'b0;
    wait_an(4'b1110);
    check("post-rst blank digit0", {8'd0, seg_out}, 16'h00FF);
    repeat (40) @(negedge clk);
    check("post-rst no ack", 16'(ack_cnt - base), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 16, clock cycles per digit slot (guard included); legal range 4..65535.
REQ-002 Parameter GUARD, default 2, cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  1 = scanning; 0 = display dark.
REQ-006 load  input  1  one-cycle strobe: capture digits_in, dp_in, blank_in.
REQ-007 digits_in  input  16  four BCD digits; [3:0] = digit 0 (least significant) ... [15:12] = digit 3.
REQ-008 dp_in  input  4  decimal point request per digit, 1 = lit.
REQ-009 blank_in  input  4  forced blank per digit, 1 = dark.
REQ-010 lz_en  input  1  1 = leading-zero suppression on.
REQ-011 seg_out  output  8  active-low segments; [6:0] = {a,b,c,d,e,f,g}; [7] = dp.
REQ-012 an_out  output  4  active-low anode select; bit i = digit i.
REQ-013 ack  output  1  one-cycle pulse when captured data becomes the displayed data.

Function
REQ-014 Decode table for seg_out[6:0]: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; codes 10-15 = 0011111.
REQ-015 FSM states OFF, GUARD, DRIVE; slot counter cnt 0..SCAN_DIV-1; digit index idx 0..3.
REQ-016 OFF: cnt=0, idx=0; en=1 moves to GUARD next cycle.
REQ-017 GUARD: cnt increments; at cnt=GUARD-1, move to DRIVE.
REQ-018 DRIVE: cnt increments; at cnt=SCAN_DIV-1, cnt becomes 0 and idx becomes (idx+1) mod 4; move to GUARD.
REQ-019 en=0 in any state: OFF on the next edge, whatever the slot position.
REQ-020 In OFF and GUARD, an_out=4'b1111 and seg_out=8'hFF.
REQ-021 In DRIVE:
  - an_out has only bit idx low.
  - seg_out = decode of active digit idx; seg_out[7] = ~dp of that digit.
REQ-022 Blanking: a digit shows seg_out=8'hFF with its anode still asserted when either holds:
  - its blank bit is set.
  - lz_en=1 and the digit and every more-significant digit equal 0.
  Digit 0 is never zero-suppressed. A blanked digit also blanks its dp.
REQ-023 seg_out and an_out are registered and reflect the FSM state of the previous cycle (one-cycle latency).
REQ-024 load writes a pending buffer and sets the pending flag; a later load before commit overwrites it (last wins).
REQ-025 Commit moves pending into the active registers and pulses ack next cycle. It occurs at either:
  - the edge where idx wraps 3->0.
  - any edge while in OFF.
REQ-026 A load in the same cycle as a commit edge commits digits_in directly, clears pending and pulses ack.
REQ-027 Active data never changes mid-frame; all four digits of one frame come from one load.

Reset
REQ-028 While rst=1, the block holds:
  - state OFF, cnt=0, idx=0, pending=0.
  - active digits 0, dp 0, blank 4'b1111.
  - an_out=4'b1111, seg_out=8'hFF, ack=0.
REQ-029 Deassertion of rst resumes per en on the next edge; rst mid-frame discards pending data without ack.

Structure
REQ-030 Shared package seg7_pkg holds:
  - FSM state enum.
  - 7-bit decode patterns and the blank constant 8'hFF.
  - default SCAN_DIV and GUARD.
REQ-031 Sub-module seg7_digit_decode: combinational 4-bit to 7-bit per REQ-014, instantiated once on the idx-selected digit.

Verification
REQ-032 Check scan timing (SCAN_DIV=8, GUARD=2, en=1 after reset):
  - an_out low for 6 of every 8 cycles per digit, order 1110, 1101, 1011, 0111.
  - 2 all-high cycles between digits.
REQ-033 Check decode (load digits_in=16'h1234, dp_in=4'b0100):
  - after the next wrap, ack pulses once.
  - digit 0 shows 8'b11001100 (4), digit 2 shows 8'b00010010 (2 plus dp).
REQ-034 Check zero suppression (digits_in=16'h0070, lz_en=1):
  - digits 3 and 2 show 8'hFF; digit 1 shows 8'b10001111 (7); digit 0 shows 8'b10000001 (0).
  - with lz_en=0, digit 3 shows 8'b10000001.
REQ-035 Check last-wins and bypass:
  - two loads (16'h1111, then 16'h2222) in one frame: a single ack, frame shows 2222.
  - a load coinciding with the wrap edge commits at that edge.
REQ-036 Check en and reset:
  - en=0 mid-DRIVE: the next output cycle shows an_out=4'b1111; a load while disabled acks next cycle.
  - rst mid-frame: outputs go to 8'hFF / 4'b1111 asynchronously.
REQ-037 Check invalid code (digits_in=16'h000C): digit 0 shows 8'b10011111.
